soc_system_result_out: RTL and testbench

//  Avalon-MM slave that returns coprocessor results to the HPS; the reverse path of the
//  HPS-written operand output port. The coprocessor pushes words through a valid/ready

---
 rtl/soc_system_result_out_if.sv | 43 ++++
 rtl/soc_system_result_out.sv | 123 ++++++++++++
 tb/tb_soc_system_result_out.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_result_out_if.sv
// -----------------------------------------------------------------------------
// soc_system_result_out_if
//   Bundles the two faces of the result-return block.
//   - The Avalon-MM slave port used by the HPS. The HPS pops results from it and
//     reads status.
//   - The valid/ready stream used by the coprocessor to push result words.
//   Modports:
//     slave  : the result-out block's view. It receives Avalon strobes and stream
//              data, and drives readdata, irq and in_ready.
//     master : the environment's view. This is the HPS plus the coprocessor.
//   Signals:
//     address[1:0], chipselect, read_n, write_n, writedata[31:0]  Avalon request
//     readdata[31:0], irq                                         Avalon response
//     in_data[DATA_WIDTH-1:0], in_valid, in_ready                 result stream
// -----------------------------------------------------------------------------
interface soc_system_result_out_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [1:0]            address;
  logic                  chipselect;
  logic                  read_n;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic                  irq;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    input  in_data, in_valid,
    output readdata, irq, in_ready
  );

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    output in_data, in_valid,
    input  readdata, irq, in_ready
  );

endinterface

// File: rtl/soc_system_result_out.sv
// -----------------------------------------------------------------------------
// soc_system_result_out
//   Avalon-MM slave that hands coprocessor results back to the HPS.
//   The coprocessor pushes words into a DEPTH-entry FIFO through a valid/ready
//   handshake. The HPS pops words by reading DATA and can poll STATUS. It can
//   also take a level interrupt when results are pending or an underflow occurs.
//   Register map (word addresses):
//     0 DATA     RO  FIFO head, popped on read. An empty read returns 0 and sets
//                    UNDERFLOW.
//     1 STATUS   RO  [0] EMPTY, [1] FULL, [2] UNDERFLOW, [3] irq, [15:8] LEVEL
//     2 IRQ_MASK RW  [0] non-empty enable, [1] underflow enable
//     3 CONTROL  WO  [0] FLUSH, [1] clear UNDERFLOW (write 1)
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    soc_system_result_out_if.slave (Avalon slave + result stream)
// -----------------------------------------------------------------------------
module soc_system_result_out #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  soc_system_result_out_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  underflow;
  logic [1:0]            irq_mask;

  logic rd;
  logic wr;
  logic empty;
  logic full;
  logic flush;
  logic push;
  logic pop;
  logic uf_set;
  logic uf_clr;
  logic [31:0] head_ext;
  logic [31:0] status;

  // Only CONTROL bits [1:0] and IRQ_MASK bits [1:0] are meaningful.
  logic [29:0] unused_writedata;
  assign unused_writedata = bus.writedata[31:2];

  assign rd     = bus.chipselect & ~bus.read_n;
  assign wr     = bus.chipselect & ~bus.write_n;
  assign empty  = (level == '0);
  assign full   = (level == LW'(DEPTH));
  assign flush  = wr & (bus.address == 2'd3) & bus.writedata[0];
  assign uf_set = rd & (bus.address == 2'd0) & empty;
  assign uf_clr = wr & (bus.address == 2'd3) & bus.writedata[1];

  // A flush cycle refuses the incoming word. This keeps a push from being lost
  // when the flush clears the FIFO in the same cycle.
  assign bus.in_ready = ~full & ~flush;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = rd & (bus.address == 2'd0) & ~empty;

  // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
  // Flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset. Entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // Sticky underflow. A set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       underflow <= 1'b0;
    else if (uf_set) underflow <= 1'b1;
    else if (uf_clr) underflow <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                irq_mask <= 2'b00;
    else if (wr && (bus.address == 2'd2))     irq_mask <= bus.writedata[1:0];
  end

  assign bus.irq = (irq_mask[0] & ~empty) | (irq_mask[1] & underflow);

  assign head_ext = 32'(mem[rd_ptr]);
  assign status   = {16'h0000, 8'(level), 4'h0, bus.irq, underflow, full, empty};

  // Zero-wait-state read mux. An empty DATA read returns 0 and never exposes
  // stale storage.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata = empty ? 32'h0 : head_ext;
      2'd1:    bus.readdata = status;
      2'd2:    bus.readdata = {30'h0, irq_mask};
      default: bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_result_out.sv
// -----------------------------------------------------------------------------
// tb_soc_system_result_out
//   Bench for soc_system_result_out.
//   Each pushed word goes into a scoreboard queue, and each DATA read pops the
//   queue and compares the result. A small model tracks the sticky underflow
//   flag and the interrupt mask. From these it predicts in_ready, irq and the
//   register reads.
// -----------------------------------------------------------------------------
module tb_soc_system_result_out;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;

  soc_system_result_out_if #(.DATA_WIDTH(32)) bus ();

  soc_system_result_out #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb_q[$];
  bit          model_uf;
  bit [1:0]    model_mask;
  logic [31:0] rdata;
  bit          accepted;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_irq();
    return (model_mask[0] && sb_q.size() != 0) || (model_mask[1] && model_uf);
  endfunction

  function automatic logic [31:0] model_status();
    logic is_empty;
    logic is_full;
    is_empty = (sb_q.size() == 0);
    is_full  = (sb_q.size() == DEPTH);
    return {16'h0000, 8'(sb_q.size()), 4'h0, model_irq(), model_uf, is_full, is_empty};
  endfunction

  // Drives one bus cycle at the falling edge. It checks the outputs from the
  // pre-edge model state, then advances the model to match the coming posedge.
  task automatic applyStimulus(input bit do_rd, input bit do_wr, input logic [1:0] addr,
                               input logic [31:0] wdata, input bit valid,
                               input logic [31:0] vdata);
    logic [31:0] exp_rd;
    bit          exp_ready;
    bit          was_empty;
    @(negedge clk);
    bus.chipselect = do_rd | do_wr;
    bus.read_n     = ~do_rd;
    bus.write_n    = ~do_wr;
    bus.address    = addr;
    bus.writedata  = wdata;
    bus.in_valid   = valid;
    bus.in_data    = vdata;
    #1;
    exp_ready = (sb_q.size() < DEPTH) && !(do_wr && addr == 2'd3 && wdata[0]);
    if (valid) checkOutput("in_ready", {31'h0, bus.in_ready}, {31'h0, exp_ready});
    checkOutput("irq", {31'h0, bus.irq}, {31'h0, model_irq()});
    rdata = bus.readdata;
    if (do_rd) begin
      case (addr)
        2'd0:    exp_rd = (sb_q.size() != 0) ? sb_q[0] : 32'h0;
        2'd1:    exp_rd = model_status();
        2'd2:    exp_rd = {30'h0, model_mask};
        default: exp_rd = 32'h0;
      endcase
      checkOutput("readdata", rdata, exp_rd);
    end
    was_empty = (sb_q.size() == 0);
    accepted  = valid && exp_ready;
    if (do_rd && addr == 2'd0 && !was_empty) void'(sb_q.pop_front());
    if (accepted) sb_q.push_back(vdata);
    if (do_wr && addr == 2'd2) model_mask = wdata[1:0];
    if (do_wr && addr == 2'd3) begin
      if (wdata[0]) sb_q.delete();
      if (wdata[1]) model_uf = 1'b0;
    end
    if (do_rd && addr == 2'd0 && was_empty) model_uf = 1'b1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic pushWord(input logic [31:0] d);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, d);
  endtask

  task automatic readReg(input logic [1:0] a);
    applyStimulus(1'b1, 1'b0, a, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, a, d, 1'b0, 32'h0);
  endtask

  initial begin
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'h0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 32'h0;
    model_uf       = 1'b0;
    model_mask     = 2'b00;
    reset          = 1'b1;
    #2;
    checkOutput("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    checkOutput("rst_irq", {31'h0, bus.irq}, 32'h0);
    checkOutput("rst_data", bus.readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 1: in-order return, then empty
    pushWord(32'h11);
    pushWord(32'h22);
    pushWord(32'h33);
    readReg(2'd0); checkOutput("t1_d0", rdata, 32'h11);
    readReg(2'd0); checkOutput("t1_d1", rdata, 32'h22);
    readReg(2'd0); checkOutput("t1_d2", rdata, 32'h33);
    readReg(2'd1); checkOutput("t1_status", rdata, 32'h1);

    // 2: fill to DEPTH, hold the ninth word, release it with one pop
    for (int i = 0; i < DEPTH; i++) pushWord(32'h100 + i);
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h0, 1'b1, 32'h200);
    checkOutput("t2_status_full", rdata, 32'h0000_0802);
    checkOutput("t2_held", {31'h0, accepted}, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 32'h200);
    checkOutput("t2_pop_head", rdata, 32'h100);
    checkOutput("t2_no_passthru", {31'h0, accepted}, 32'h0);
    pushWord(32'h200);
    checkOutput("t2_ninth_taken", {31'h0, accepted}, 32'h1);
    for (int i = 0; i < DEPTH; i++) readReg(2'd0);
    checkOutput("t2_last", rdata, 32'h200);
    readReg(2'd1); checkOutput("t2_status_empty", rdata, 32'h1);

    // 3: underflow set, clear, and hold
    readReg(2'd0); checkOutput("t3_empty_read", rdata, 32'h0);
    readReg(2'd1); checkOutput("t3_status_uf", rdata, 32'h5);
    writeReg(2'd3, 32'h2);
    readReg(2'd1); checkOutput("t3_status_clr", rdata, 32'h1);
    readReg(2'd0);
    applyStimulus(1'b1, 1'b1, 2'd0, 32'h2, 1'b0, 32'h0);
    readReg(2'd1); checkOutput("t3_uf_hold", rdata, 32'h5);
    writeReg(2'd3, 32'h2);

    // 4: interrupt on non-empty and on underflow
    writeReg(2'd2, 32'h1);
    pushWord(32'hA5);
    checkOutput("t4_irq_pre", {31'h0, bus.irq}, 32'h0);
    idleCycle();
    checkOutput("t4_irq_rise", {31'h0, bus.irq}, 32'h1);
    readReg(2'd0); checkOutput("t4_data", rdata, 32'hA5);
    idleCycle();
    checkOutput("t4_irq_fall", {31'h0, bus.irq}, 32'h0);
    writeReg(2'd2, 32'h2);
    readReg(2'd0);
    idleCycle();
    checkOutput("t4_irq_uf", {31'h0, bus.irq}, 32'h1);
    readReg(2'd1); checkOutput("t4_status", rdata, 32'hD);
    writeReg(2'd3, 32'h2);
    writeReg(2'd2, 32'h0);

    // 5: flush blocks a simultaneous push, the word is taken afterwards
    for (int i = 0; i < 5; i++) pushWord(32'h300 + i);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h1, 1'b1, 32'h55);
    checkOutput("t5_flush_block", {31'h0, accepted}, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h0, 1'b1, 32'h55);
    checkOutput("t5_level0", rdata, 32'h1);
    checkOutput("t5_retry", {31'h0, accepted}, 32'h1);
    readReg(2'd0); checkOutput("t5_word", rdata, 32'h55);

    // 6: steady push+pop across pointer wrap, then async reset mid-stream
    for (int i = 0; i < 3; i++) pushWord(32'h600 + i);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 32'h610 + i);
    readReg(2'd1); checkOutput("t6_level", rdata, 32'h0000_0300);
    writeReg(2'd2, 32'h1);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 32'h700);
    checkOutput("t6_irq_before", {31'h0, bus.irq}, 32'h1);
    #1;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.in_valid   = 1'b0;
    bus.address    = 2'd0;
    reset          = 1'b1;
    #1;
    checkOutput("t6_rst_ready", {31'h0, bus.in_ready}, 32'h1);
    checkOutput("t6_rst_irq", {31'h0, bus.irq}, 32'h0);
    checkOutput("t6_rst_data", bus.readdata, 32'h0);
    bus.address = 2'd1;
    #1;
    checkOutput("t6_rst_status", bus.readdata, 32'h1);
    sb_q.delete();
    model_uf   = 1'b0;
    model_mask = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    pushWord(32'h801);
    readReg(2'd0); checkOutput("t6_after_rst", rdata, 32'h801);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
